// File: rtl/rsa_modexp_core_if.sv
// Request/response bundle for the modular exponentiation core.
// The requester drives the operands and start; the core drives status and result.
interface rsa_modexp_core_if #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [WIDTH-1:0]     result;

    modport master (
        output start, base, exponent, modulus,
        input  busy, done, error, result
    );

    modport slave (
        input  start, base, exponent, modulus,
        output busy, done, error, result
    );
endinterface

// File: rtl/rsa_modexp_core.sv
// Left-to-right square-and-multiply B^E mod M built on a
// bit-serial interleaved modular multiplier (one bit per cycle).
module rsa_modexp_core #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    rsa_modexp_core_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SQR,
        MUL,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH:0]       p_q, p_d;
    logic [IW-1:0]        i_q, i_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     res_q, res_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   p_dbl;
    logic [WIDTH:0]   p_dbl_r;
    logic [WIDTH:0]   p_add;
    logic [WIDTH:0]   p_add_r;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] y_op;
    logic             x_bit;

    // Scan the bits of R, accumulating the other operand (R or B).
    // P < M holds throughout, so 2P and P+Y fit in WIDTH+1 bits.
    assign m_ext   = {1'b0, m_q};
    assign y_op    = (state_q == MUL) ? b_q : r_q;
    assign x_bit   = r_q[cnt_q];
    assign p_dbl   = p_q << 1;
    assign p_dbl_r = (p_dbl >= m_ext) ? p_dbl - m_ext : p_dbl;
    assign p_add   = p_dbl_r + {1'b0, y_op};
    assign p_add_r = (p_add >= m_ext) ? p_add - m_ext : p_add;
    assign p_next  = x_bit ? p_add_r : p_dbl_r;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        e_d     = e_q;
        m_d     = m_q;
        r_d     = r_q;
        p_d     = p_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    b_d     = bus.base;
                    e_d     = bus.exponent;
                    m_d     = bus.modulus;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (m_q < WIDTH'(2) || b_q >= m_q) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = DONE;
                end else begin
                    r_d     = WIDTH'(1);
                    p_d     = '0;
                    i_d     = IW'(EXP_WIDTH - 1);
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = SQR;
                end
            end
            SQR, MUL: begin
                p_d   = p_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    r_d   = p_next[WIDTH-1:0];
                    p_d   = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if (state_q == SQR && e_q[i_q]) begin
                        state_d = MUL;
                    end else if (i_q == '0) begin
                        res_d   = p_next[WIDTH-1:0];
                        state_d = DONE;
                    end else begin
                        i_d     = i_q - 1'b1;
                        state_d = SQR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            p_q     <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            e_q     <= e_d;
            m_q     <= m_d;
            r_q     <= r_d;
            p_q     <= p_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.error  = err_q;
    assign bus.result = res_q;
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed and randomized checks of rsa_modexp_core against an
// arithmetic model of B^E mod M and its cycle latency.
module tb_rsa_modexp_core;
    localparam int W  = 8;
    localparam int EW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rsa_modexp_core_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

    rsa_modexp_core #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int b, input int e, input int m,
                                  output int res, output bit err,
                                  output int lat);
        longint r;
        int     pc;
        err = (m < 2) || (b >= m);
        res = 0;
        lat = 2;
        if (!err) begin
            r  = 1;
            pc = 0;
            for (int i = EW - 1; i >= 0; i--) begin
                r = (r * r) % m;
                if (e[i]) begin
                    r = (r * b) % m;
                    pc++;
                end
            end
            res = int'(r);
            lat = 2 + W * (EW + pc);
        end
    endfunction

    // Latency N means done is visible just before the Nth edge after accept.
    task automatic run(input int b, input int e, input int m,
                       input bit inject);
        int res, lat, k;
        bit err, seen;
        model(b, e, m, res, err, lat);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.base     = W'(b);
        bus.exponent = EW'(e);
        bus.modulus  = W'(m);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.base     = W'($urandom);
        bus.exponent = EW'($urandom);
        bus.modulus  = W'($urandom);
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
            @(negedge clk);
            bus.start = inject && (k == 9);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            k++;
            if (bus.done) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("latency", 64'(k + 1), 64'(lat));
            chk("result", 64'(bus.result), 64'(res));
            chk("error", 64'(bus.error), 64'(err));
            @(negedge clk);
            bus.start = inject;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            chk("done_one_cycle", 64'(bus.done), 64'd0);
            chk("idle_after_done", 64'(bus.busy), 64'd0);
            chk("result_held", 64'(bus.result), 64'(res));
            @(posedge clk);
            #1;
            chk("no_restart", 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        int m, b, e;
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;
        bus.modulus  = '0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(5, 3, 13, 1'b0);
        run(7, 0, 11, 1'b0);
        run(254, 255, 255, 1'b0);
        run(5, 3, 1, 1'b0);
        run(20, 5, 13, 1'b0);
        run(5, 3, 13, 1'b1);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.base     = 8'd5;
        bus.exponent = 8'd3;
        bus.modulus  = 8'd13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (39) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_error", 64'(bus.error), 64'd0);
        chk("abort_result", 64'(bus.result), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 64'(bus.done), 64'd0);
        end
        run(2, 10, 255, 1'b0);

        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(2, 255);
            b = $urandom_range(0, m - 1);
            e = $urandom_range(0, 255);
            case (i % 5)
                0: begin
                    m = (m < 4) ? 4 : (m & 'hFE);
                    b = $urandom_range(0, m - 1);
                end
                1: b = 0;
                2: b = m - 1;
                3: e = 255;
                default: begin
                    m = $urandom_range(0, 255);
                    b = $urandom_range(0, 255);
                end
            endcase
            run(b, e, m, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
